eth_pcs_scrambler_pipe: RTL and testbench
=========================================

Name: eth_pcs_scrambler_pipe

Overview:
- Parametrised, pipelined self-synchronous scrambler/descrambler for the 10G PCS. Polynomial: 1 + x^39 + x^58.
- Datapath width is selectable (16/32/64) and carries a valid qualifier and a 2-bit sync header alongside the data. The header is never scrambled.
- Adds a runtime bypass, a seed load and a descrambler lock indication.
- Scrambler mode sits between the 64b/66b encoder and the gearbox. Descrambler mode sits between block lock and the decoder.

Parameters:
- W_DATA, 32, payload width per beat; legal values 16, 32, 64.
- SCR_MODE, 0, 0 = scrambler, 1 = descrambler.
- SCR_BYPASS, 0, 1 = force bypass permanently (ORed with i_bypass).
- SCR_SEED, all-ones (58 bits), state value loaded at reset and on i_seed_load.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_clk_en  in  1  clock enable (gearbox stall); all registers hold when low.
- i_bypass  in  1  runtime bypass, quasi-static.
- i_seed_load  in  1  pulse; reload state with SCR_SEED.
- i_valid  in  1  input beat valid.
- i_hdr  in  2  sync header, passed through unscrambled.
- i_data  in  W_DATA  payload; bit 0 is transmitted first.
- o_valid  out  1  output beat valid.
- o_hdr  out  2  delayed header.
- o_data  out  W_DATA  scrambled, descrambled or bypassed payload.
- o_locked  out  1  descrambler state fully flushed with line data.

Behaviour:
- State S[57:0], where S[0] is the most recent line bit.
- Bits of a beat are processed serially, k = 0..W_DATA-1.
- Per bit: out[k] = in[k] ^ S[38] ^ S[57].
- State update per bit:
  - Scrambler: S <= {S[56:0], out[k]}.
  - Descrambler: S <= {S[56:0], in[k]}.
- The whole beat is unrolled combinationally; one state update per beat.
- Accepted beat = i_clk_en & i_valid. State advances only on accepted beats.
- Latency is exactly 1 cycle. On every i_clk_en edge:
  - o_valid <= i_valid.
  - o_hdr <= i_hdr.
  - o_data <= bypass ? i_data : scrambled result.
  - On non-accepted (i_valid=0) cycles, o_data and o_hdr still load from the inputs; o_valid=0 marks them don't-care.
- i_clk_en low: every register, including state, lock counter and outputs, holds its value.
- Bypass (i_bypass | SCR_BYPASS):
  - Affects only o_data selection.
  - State keeps advancing per mode, so leaving bypass resumes the stream as if bypass never occurred.
  - Toggling takes effect on the next accepted beat.
- Seed load:
  - Honoured only on i_clk_en cycles.
  - If coincident with an accepted beat, that beat is processed starting from SCR_SEED, and the post-beat state is stored.
  - In descrambler mode it also clears the lock counter.
- Lock (descrambler mode):
  - LOCK_BEATS = ceil(58/W_DATA), i.e. 4/2/1 for W_DATA = 16/32/64.
  - Saturating counter cnt of accepted beats.
  - On an accepted beat, o_locked <= (cnt >= LOCK_BEATS), with cnt sampled before increment.
  - o_locked therefore first rises together with output beat LOCK_BEATS+1 (1-based), the first beat decoded from fully line-derived state.
  - o_locked stays high until reset or seed load.
- Lock (scrambler mode): o_locked is tied to 1 constantly; no counter is present.
- Reset (async assert, release synchronous to i_clk):
  - S = SCR_SEED, cnt = 0.
  - o_valid = 0, o_hdr = 0, o_data = 0.
  - o_locked = 0 in descrambler mode.
  - Reset mid-stream: outputs clear immediately and the next accepted beat restarts from the seed.
- Illegal W_DATA: elaboration error.

Test Plan:
- Scrambler, W_DATA=32, seed all-ones, i_bypass=0, three accepted beats of 32'h0 with i_hdr=2'b01 -> o_data = 32'h00000000, then 32'h03FFFF80, then matches the golden model; o_hdr = 2'b01 with 1-cycle latency.
- Scrambler feeding descrambler, W_DATA in {16, 32, 64}, 1000 random beats -> descrambler o_data equals the original payload from output beat LOCK_BEATS+1 onward (beat 5/3/2). o_locked rises on exactly that beat.
- i_clk_en low for 3 cycles mid-stream with i_valid=1 -> o_valid, o_data, o_hdr and state hold. The resumed stream matches the golden model with no lost or duplicated beat.
- i_bypass high for beats 10..14 -> o_data = i_data for those beats. Beat 15 equals the golden model computed with bypass never asserted.
- Descrambler locked, i_seed_load pulsed together with an accepted beat -> that beat is descrambled from SCR_SEED; o_locked drops at the next output and re-rises after LOCK_BEATS further beats.
- i_reset_n asserted mid-beat -> o_valid, o_data and o_locked go to 0 without waiting for a clock edge. After release the first output beat matches the golden model starting from seed.

Source files
------------

// File: rtl/eth_pcs_scrambler_pipe.sv
// Self-synchronous 1 + x^39 + x^58 scrambler/descrambler for the 10G PCS.
// Whole beat unrolled per cycle, one-cycle latency, header passed through untouched.
module eth_pcs_scrambler_pipe #(
    parameter int unsigned W_DATA     = 32,
    parameter bit          SCR_MODE   = 1'b0,
    parameter bit          SCR_BYPASS = 1'b0,
    parameter logic [57:0] SCR_SEED   = '1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clk_en,
    input  logic              i_bypass,
    input  logic              i_seed_load,
    input  logic              i_valid,
    input  logic [1:0]        i_hdr,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_valid,
    output logic [1:0]        o_hdr,
    output logic [W_DATA-1:0] o_data,
    output logic              o_locked
);

    if (W_DATA != 16 && W_DATA != 32 && W_DATA != 64) begin : g_bad_width
        $error("eth_pcs_scrambler_pipe: W_DATA must be 16, 32 or 64");
    end

    logic [57:0]       state_reg;
    logic [57:0]       state_next;
    logic [57:0]       walk_state;
    logic [W_DATA-1:0] scr_data;
    logic              valid_reg;
    logic [1:0]        hdr_reg;
    logic [W_DATA-1:0] data_reg;
    logic              bypass;

    assign bypass = i_bypass | SCR_BYPASS;

    // S[0] is the newest line bit; bit 0 of the beat goes through first.
    always_comb begin
        walk_state = i_seed_load ? SCR_SEED : state_reg;
        scr_data   = '0;
        for (int k = 0; k < W_DATA; k++) begin
            scr_data[k] = i_data[k] ^ walk_state[38] ^ walk_state[57];
            walk_state  = {walk_state[56:0], SCR_MODE ? i_data[k] : scr_data[k]};
        end
        state_next = walk_state;
    end

    // State advances even in bypass so the stream resumes seamlessly.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= SCR_SEED;
            valid_reg <= 1'b0;
            hdr_reg   <= 2'b00;
            data_reg  <= '0;
        end else if (i_clk_en) begin
            valid_reg <= i_valid;
            hdr_reg   <= i_hdr;
            data_reg  <= bypass ? i_data : scr_data;
            if (i_valid) begin
                state_reg <= state_next;
            end else if (i_seed_load) begin
                state_reg <= SCR_SEED;
            end
        end
    end

    assign o_valid = valid_reg;
    assign o_hdr   = hdr_reg;
    assign o_data  = data_reg;

    if (SCR_MODE) begin : g_lock
        localparam int unsigned LOCK_BEATS = (58 + W_DATA - 1) / W_DATA;
        localparam int unsigned CNT_W      = $clog2(LOCK_BEATS + 1);

        logic [CNT_W-1:0] cnt_reg;
        logic             locked_reg;

        // Locked once every state bit used for a beat came from the line.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                cnt_reg    <= '0;
                locked_reg <= 1'b0;
            end else if (i_clk_en) begin
                if (i_seed_load) begin
                    cnt_reg    <= i_valid ? CNT_W'(1) : '0;
                    locked_reg <= 1'b0;
                end else if (i_valid) begin
                    locked_reg <= (cnt_reg >= CNT_W'(LOCK_BEATS));
                    if (cnt_reg < CNT_W'(LOCK_BEATS)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
        end

        assign o_locked = locked_reg;
    end else begin : g_no_lock
        assign o_locked = 1'b1;
    end

endmodule

// File: tb/tb_eth_pcs_scrambler_pipe.sv
// Bench for eth_pcs_scrambler_pipe: 32-bit scrambler/descrambler pair on a shared
// stimulus with a scoreboard, plus scrambler->descrambler loops at 16/32/64 bits.
module tb_eth_pcs_scrambler_pipe;

    localparam logic [57:0] SEED = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit-serial reference of the line code.
    function automatic logic [31:0] model(input bit mode, inout logic [57:0] s, input logic [31:0] din);
        logic [31:0] o;
        logic        b;
        o = '0;
        for (int k = 0; k < 32; k++) begin
            b    = din[k] ^ s[38] ^ s[57];
            o[k] = b;
            s    = {s[56:0], mode ? din[k] : b};
        end
        return o;
    endfunction

    logic        rst_n;
    logic        clk_en;
    logic        valid;
    logic [1:0]  hdr;
    logic [31:0] data;
    logic        bypass;
    logic        seed_load;

    logic        s_valid, d_valid, s_locked, d_locked;
    logic [1:0]  s_hdr, d_hdr;
    logic [31:0] s_data, d_data;

    eth_pcs_scrambler_pipe #(.W_DATA(32), .SCR_MODE(1'b0), .SCR_BYPASS(1'b0), .SCR_SEED(SEED)) dut_s (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(clk_en), .i_bypass(bypass),
        .i_seed_load(seed_load), .i_valid(valid), .i_hdr(hdr), .i_data(data),
        .o_valid(s_valid), .o_hdr(s_hdr), .o_data(s_data), .o_locked(s_locked)
    );

    eth_pcs_scrambler_pipe #(.W_DATA(32), .SCR_MODE(1'b1), .SCR_BYPASS(1'b0), .SCR_SEED(SEED)) dut_d (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(clk_en), .i_bypass(bypass),
        .i_seed_load(seed_load), .i_valid(valid), .i_hdr(hdr), .i_data(data),
        .o_valid(d_valid), .o_hdr(d_hdr), .o_data(d_data), .o_locked(d_locked)
    );

    typedef struct {
        bit          v;
        logic [1:0]  hdr;
        logic [31:0] sdata;
        logic [31:0] ddata;
        bit          lk;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    bit          have_cur = 1'b0;
    logic        upd;
    int          mon_n = 0;

    logic [57:0] s_state, d_state;
    int          lock_cnt;
    bit          lock_exp;
    bit          hand_en;
    logic [31:0] hand_val;

    // One call per clock: sets inputs for the next edge and queues the expected output.
    task automatic drive(input bit v, input logic [1:0] h, input logic [31:0] d,
                         input bit en, input bit byp, input bit sl);
        exp_t        e;
        logic [57:0] st, dt;
        logic [31:0] so, dout;
        clk_en = en; valid = v; hdr = h; data = d; bypass = byp; seed_load = sl;
        if (en) begin
            st   = sl ? SEED : s_state;
            dt   = sl ? SEED : d_state;
            so   = model(1'b0, st, d);
            dout = model(1'b1, dt, d);
            if (v) begin
                s_state = st;
                d_state = dt;
            end else if (sl) begin
                s_state = SEED;
                d_state = SEED;
            end
            if (sl) begin
                lock_cnt = v ? 1 : 0;
                lock_exp = 1'b0;
            end else if (v) begin
                lock_exp = (lock_cnt >= 2);
                if (lock_cnt < 2) lock_cnt++;
            end
            e.v     = v;
            e.hdr   = h;
            e.sdata = byp ? d : (hand_en ? hand_val : so);
            e.ddata = byp ? d : dout;
            e.lk    = lock_exp;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) upd <= 1'b0;
        else        upd <= clk_en;
    end

    // Pops one entry per enabled edge; on stalled edges the last entry must still hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_cur = 1'b0;
        end else begin
            if (upd) begin
                if (q.size() == 0) begin
                    check("main_underflow", 64'(q.size()), 64'd1);
                end else begin
                    cur      = q.pop_front();
                    have_cur = 1'b1;
                    mon_n++;
                    $display("main beat %0d v=%0b hdr=%b scr=%h dsc=%h locked=%0b",
                             mon_n, s_valid, s_hdr, s_data, d_data, d_locked);
                end
            end
            if (have_cur) begin
                check("s_valid", 64'(s_valid), 64'(cur.v));
                check("d_valid", 64'(d_valid), 64'(cur.v));
                check("s_locked", 64'(s_locked), 64'd1);
                check("d_locked", 64'(d_locked), 64'(cur.lk));
                if (cur.v) begin
                    check("s_data", 64'(s_data), 64'(cur.sdata));
                    check("d_data", 64'(d_data), 64'(cur.ddata));
                    check("s_hdr", 64'(s_hdr), 64'(cur.hdr));
                    check("d_hdr", 64'(d_hdr), 64'(cur.hdr));
                end
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chain
        localparam int CW = 16 << gi;
        localparam int LB = (58 + CW - 1) / CW;

        logic          c_rst_n = 1'b0;
        logic          c_valid = 1'b0;
        logic [1:0]    c_hdr   = 2'b00;
        logic [CW-1:0] c_data  = '0;
        logic          l_valid, l_locked, r_valid, r_locked;
        logic [1:0]    l_hdr, r_hdr;
        logic [CW-1:0] l_data, r_data;
        logic [CW+1:0] pq[$];
        logic [CW+1:0] pexp;
        int            nb   = 0;
        bit            done = 1'b0;

        eth_pcs_scrambler_pipe #(.W_DATA(CW), .SCR_MODE(1'b0), .SCR_BYPASS(1'b0), .SCR_SEED(SEED)) u_scr (
            .i_clk(clk), .i_reset_n(c_rst_n), .i_clk_en(1'b1), .i_bypass(1'b0),
            .i_seed_load(1'b0), .i_valid(c_valid), .i_hdr(c_hdr), .i_data(c_data),
            .o_valid(l_valid), .o_hdr(l_hdr), .o_data(l_data), .o_locked(l_locked)
        );

        eth_pcs_scrambler_pipe #(.W_DATA(CW), .SCR_MODE(1'b1), .SCR_BYPASS(1'b0), .SCR_SEED(SEED)) u_dsc (
            .i_clk(clk), .i_reset_n(c_rst_n), .i_clk_en(1'b1), .i_bypass(1'b0),
            .i_seed_load(1'b0), .i_valid(l_valid), .i_hdr(l_hdr), .i_data(l_data),
            .o_valid(r_valid), .o_hdr(r_hdr), .o_data(r_data), .o_locked(r_locked)
        );

        initial begin
            logic [63:0] r;
            int          sent;
            sent = 0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            c_rst_n = 1'b1;
            while (sent < 1000) begin
                @(posedge clk);
                #1;
                r       = {$urandom(), $urandom()};
                c_valid = ($urandom_range(0, 7) != 0);
                c_hdr   = 2'($urandom_range(1, 2));
                c_data  = r[CW-1:0];
                if (c_valid) begin
                    pq.push_back({c_hdr, c_data});
                    sent++;
                end
            end
            @(posedge clk);
            #1;
            c_valid = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            #1;
            check($sformatf("chain%0d_drained", CW), 64'(pq.size()), 64'd0);
            done = 1'b1;
        end

        // Same seed on both ends, so payload is recovered from the first beat;
        // lock must rise exactly on output beat LB+1.
        always @(negedge clk) begin
            if (c_rst_n && r_valid) begin
                nb++;
                if (pq.size() == 0) begin
                    check($sformatf("chain%0d_underflow", CW), 64'(pq.size()), 64'd1);
                end else begin
                    pexp = pq.pop_front();
                    $display("chain W=%0d beat %0d hdr=%b data=%h locked=%0b", CW, nb, r_hdr, r_data, r_locked);
                    check($sformatf("chain%0d_data", CW), 64'(r_data), 64'(pexp[CW-1:0]));
                    check($sformatf("chain%0d_hdr", CW), 64'(r_hdr), 64'(pexp[CW+1:CW]));
                end
                check($sformatf("chain%0d_locked", CW), 64'(r_locked), 64'(nb >= LB + 1));
            end
        end
    end

    initial begin
        bit all_done;
        rst_n = 1'b0; clk_en = 1'b0; valid = 1'b0; hdr = 2'b00; data = '0;
        bypass = 1'b0; seed_load = 1'b0;
        s_state = SEED; d_state = SEED; lock_cnt = 0; lock_exp = 1'b0;
        hand_en = 1'b0; hand_val = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_s_valid", 64'(s_valid), 64'd0);
        check("rst_s_hdr", 64'(s_hdr), 64'd0);
        check("rst_s_data", 64'(s_data), 64'd0);
        check("rst_s_locked", 64'(s_locked), 64'd1);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_d_data", 64'(d_data), 64'd0);
        check("rst_d_locked", 64'(d_locked), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero payload from the all-ones seed, values worked out by hand.
        hand_en = 1'b1;
        hand_val = 32'h0000_0000; drive(1'b1, 2'b01, 32'h0, 1'b1, 1'b0, 1'b0);
        hand_val = 32'h03FF_FF80; drive(1'b1, 2'b01, 32'h0, 1'b1, 1'b0, 1'b0);
        hand_val = 32'hFFFF_C000; drive(1'b1, 2'b01, 32'h0, 1'b1, 1'b0, 1'b0);
        hand_en = 1'b0;

        for (int i = 0; i < 20; i++)
            drive((i % 5) != 4, 2'($urandom_range(1, 2)), $urandom(), 1'b1, 1'b0, 1'b0);

        // Gearbox stall with data still offered.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 2'b10, $urandom(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 2'($urandom_range(1, 2)), $urandom(), 1'b1, 1'b0, 1'b0);

        // Bypass over beats 10..14 of this run.
        for (int i = 1; i <= 16; i++)
            drive(1'b1, 2'($urandom_range(1, 2)), $urandom(), 1'b1, (i >= 10 && i <= 14), 1'b0);

        // Seed reload coincident with an accepted beat while locked.
        drive(1'b1, 2'b01, $urandom(), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 2'($urandom_range(1, 2)), $urandom(), 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        q.delete();
        s_state = SEED; d_state = SEED; lock_cnt = 0; lock_exp = 1'b0;
        #1;
        check("async_s_valid", 64'(s_valid), 64'd0);
        check("async_s_data", 64'(s_data), 64'd0);
        check("async_s_hdr", 64'(s_hdr), 64'd0);
        check("async_d_valid", 64'(d_valid), 64'd0);
        check("async_d_data", 64'(d_data), 64'd0);
        check("async_d_locked", 64'(d_locked), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            drive(1'b1, 2'($urandom_range(1, 2)), $urandom(), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)
            drive(1'b0, 2'b00, $urandom(), 1'b1, 1'b0, 1'b0);
        clk_en = 1'b0;

        all_done = 1'b0;
        for (int i = 0; i < 4000 && !all_done; i++) begin
            @(posedge clk);
            all_done = g_chain[0].done && g_chain[1].done && g_chain[2].done;
        end
        check("chains_done", 64'(all_done), 64'd1);
        @(negedge clk);
        #1;
        check("main_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
